// File: rtl/seg7_scan_ctrl.sv
// Multiplexed 7-segment scan controller: double-buffered digits, blank-then-show slots,
// registered active-low anode/segment drive. Optional macro LEADING_ZERO_BLANK_EN.
module seg7_scan_ctrl #(
  parameter int NUM_DIGITS = 4,
  parameter int CLK_DIV    = 50000,
  parameter int BLANK_CYC  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  output logic [3:0]              dig_4bits,
  input  logic [7:0]              seg7_dec,
  output logic [7:0]              seg7_out,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_done
);

  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  typedef enum logic [1:0] {IDLE, BLANK, SHOW} state_t;

  state_t                  state, state_nxt;
  logic [CNT_W-1:0]        cnt, cnt_nxt;
  logic [IDX_W-1:0]        idx, idx_nxt;
  logic [4*NUM_DIGITS-1:0] pend, act;
  logic [NUM_DIGITS-1:0]   dp_pend, dp_act;
  logic                    wrap, enter, blank_cur;
  logic [NUM_DIGITS-1:0]   an_nxt;
  logic [7:0]              seg_nxt;

  assign dig_4bits = act[4*idx +: 4];

`ifdef LEADING_ZERO_BLANK_EN
  // zero_from[k]: digit k and every more significant digit hold 0
  logic [NUM_DIGITS-1:0] zero_from;
  for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_lz
    assign zero_from[k] = ~|act[4*NUM_DIGITS-1:4*k];
  end
  assign blank_cur = (idx != '0) && zero_from[idx] && !dp_act[idx];
`else
  assign blank_cur = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    idx_nxt   = idx;
    wrap      = 1'b0;
    enter     = 1'b0;
    case (state)
      IDLE: begin
        cnt_nxt = '0;
        idx_nxt = '0;
        if (en) begin
          state_nxt = BLANK;
          enter     = 1'b1;
        end
      end
      BLANK: begin
        cnt_nxt = cnt + 1'b1;
        if (cnt == CNT_W'(BLANK_CYC - 1)) state_nxt = SHOW;
      end
      SHOW: begin
        if (cnt == CNT_W'(CLK_DIV - 1)) begin
          state_nxt = BLANK;
          cnt_nxt   = '0;
          if (idx == IDX_W'(NUM_DIGITS - 1)) begin
            idx_nxt = '0;
            wrap    = 1'b1;
          end else begin
            idx_nxt = idx + 1'b1;
          end
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
    // Dropping en wins over any slot progress and suppresses frame_done
    if (!en) begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
      idx_nxt   = '0;
      wrap      = 1'b0;
      enter     = 1'b0;
    end
  end

  // Outputs follow the current state, so they lag state/idx by one cycle; en=0 darkens at once
  always_comb begin
    an_nxt  = '1;
    seg_nxt = 8'hFF;
    if (en && state == SHOW && !blank_cur) begin
      an_nxt  = ~(NUM_DIGITS'(1) << idx);
      seg_nxt = {~dp_act[idx] & seg7_dec[7], seg7_dec[6:0]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      idx        <= '0;
      pend       <= '0;
      act        <= '0;
      dp_pend    <= '0;
      dp_act     <= '0;
      an         <= '1;
      seg7_out   <= 8'hFF;
      frame_done <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      idx        <= idx_nxt;
      an         <= an_nxt;
      seg7_out   <= seg_nxt;
      frame_done <= wrap;
      if (load) begin
        pend    <= digits_in;
        dp_pend <= dp_in;
      end
      if (wrap || enter) begin
        act    <= load ? digits_in : pend;
        dp_act <= load ? dp_in : dp_pend;
      end
    end
  end

endmodule
